// File: rtl/alu4_chain_seq.sv
// Multi-nibble command sequencer for an external combinational 4-bit alu4.
// Splits one W-bit command into NIBBLES slice issues with carry/shift chaining, then returns the result.
module alu4_chain_seq #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic [5:0]   cmd_op,
  input  logic         cmd_binv,
  input  logic         cmd_y,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_s,
  output logic         rsp_c,
  output logic         rsp_z,
  output logic         rsp_v,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic         alu_binv,
  output logic         alu_y,
  output logic [5:0]   alu_op,
  input  logic [3:0]   alu_s,
  input  logic         alu_c,
  input  logic         alu_zero,
  input  logic         alu_ovf
);

  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    prime_q, prime_d;
  logic [NIBBLES-1:0][3:0] a_q, a_d;
  logic [NIBBLES-1:0][3:0] b_q, b_d;
  logic [1:0]              func_q, func_d;
  logic [1:0]              bmode_q, bmode_d;
  logic                    binv_q, binv_d;
  logic                    msb_q, msb_d;
  logic                    y_first_q, y_first_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [NIBBLES-1:0][3:0] rsp_s_q, rsp_s_d;
  logic                    rsp_c_q, rsp_c_d;
  logic                    rsp_z_q, rsp_z_d;
  logic                    rsp_v_q, rsp_v_d;
  logic [3:0]              alu_a_q, alu_a_d;
  logic [3:0]              alu_b_q, alu_b_d;
  logic                    alu_binv_q, alu_binv_d;
  logic                    alu_y_q, alu_y_d;
  logic [5:0]              alu_op_q, alu_op_d;

  logic [CW-1:0] cur;
  logic [CW-1:0] nxt;
  logic          y_sel;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prime_d     = prime_q;
    a_d         = a_q;
    b_d         = b_q;
    func_d      = func_q;
    bmode_d     = bmode_q;
    binv_d      = binv_q;
    msb_d       = msb_q;
    y_first_d   = y_first_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_s_d     = rsp_s_q;
    rsp_c_d     = rsp_c_q;
    rsp_z_d     = rsp_z_q;
    rsp_v_d     = rsp_v_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_binv_d  = alu_binv_q;
    alu_y_d     = alu_y_q;
    alu_op_d    = alu_op_q;

    // cnt counts issued slices; cur is the slice currently on the alu_* outputs
    cur = msb_q ? (CW'(NIBBLES - 1) - cnt_q) : cnt_q;
    nxt = msb_q ? (cur - CW'(1)) : (cur + CW'(1));

    case (cmd_op[3:2])
      2'b00:   y_sel = cmd_y;
      2'b01:   y_sel = 1'b1;
      2'b10:   y_sel = 1'b0;
      default: y_sel = cmd_binv ? cmd_a[0] : cmd_a[W-1];
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          a_d         = cmd_a;
          b_d         = cmd_b;
          func_d      = cmd_op[1:0];
          bmode_d     = cmd_op[5:4];
          binv_d      = cmd_binv;
          msb_d       = (cmd_op[5:4] == 2'b11);
          y_first_d   = y_sel;
          cnt_d       = '0;
          prime_d     = 1'b1;
          rsp_z_d     = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = S_EXEC;
        end
      end
      S_EXEC: begin
        if (prime_q) begin
          alu_a_d    = a_q[cur];
          alu_b_d    = b_q[cur];
          alu_y_d    = y_first_q;
          alu_binv_d = binv_q;
          alu_op_d   = {bmode_q, 2'b00, func_q};
          prime_d    = 1'b0;
        end else begin
          // alu_* inputs are only consumed here, so X elsewhere never reaches state
          rsp_s_d[cur] = alu_s;
          rsp_z_d      = rsp_z_q & alu_zero;
          rsp_c_d      = alu_c;
          rsp_v_d      = msb_q ? 1'b0 : alu_ovf;
          if (cnt_q == CW'(NIBBLES - 1)) begin
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            alu_a_d = a_q[nxt];
            alu_b_d = b_q[nxt];
            alu_y_d = msb_q ? a_q[cur][0] : alu_c;
            alu_op_d[5:4] = (bmode_q == 2'b01) ? 2'b10 : bmode_q;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      prime_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      func_q      <= '0;
      bmode_q     <= '0;
      binv_q      <= 1'b0;
      msb_q       <= 1'b0;
      y_first_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_s_q     <= '0;
      rsp_c_q     <= 1'b0;
      rsp_z_q     <= 1'b0;
      rsp_v_q     <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_binv_q  <= 1'b0;
      alu_y_q     <= 1'b0;
      alu_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prime_q     <= prime_d;
      a_q         <= a_d;
      b_q         <= b_d;
      func_q      <= func_d;
      bmode_q     <= bmode_d;
      binv_q      <= binv_d;
      msb_q       <= msb_d;
      y_first_q   <= y_first_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_s_q     <= rsp_s_d;
      rsp_c_q     <= rsp_c_d;
      rsp_z_q     <= rsp_z_d;
      rsp_v_q     <= rsp_v_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_binv_q  <= alu_binv_d;
      alu_y_q     <= alu_y_d;
      alu_op_q    <= alu_op_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_v     = rsp_v_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_binv  = alu_binv_q;
  assign alu_y     = alu_y_q;
  assign alu_op    = alu_op_q;

endmodule

// File: tb/tb_alu4_chain_seq.sv
// Bench for alu4_chain_seq: slice-level alu4 stub plus a full-width reference model of each command.
// Directed cases, random commands, back-pressure and mid-operation reset.
module tb_alu4_chain_seq;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n, cmd_valid, cmd_ready, cmd_binv, cmd_y;
  logic [W-1:0] cmd_a, cmd_b, rsp_s;
  logic [5:0]   cmd_op, alu_op;
  logic         rsp_valid, rsp_ready, rsp_c, rsp_z, rsp_v;
  logic [3:0]   alu_a, alu_b, alu_s;
  logic         alu_binv, alu_y, alu_c, alu_zero, alu_ovf;

  int checks = 0;
  int errors = 0;
  int alu_bad = 0;
  logic [1:0] slice_mode [N];

  always #5 clk = ~clk;

  alu4_chain_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_binv(cmd_binv), .cmd_y(cmd_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s), .rsp_c(rsp_c), .rsp_z(rsp_z), .rsp_v(rsp_v),
    .alu_a(alu_a), .alu_b(alu_b), .alu_binv(alu_binv), .alu_y(alu_y), .alu_op(alu_op),
    .alu_s(alu_s), .alu_c(alu_c), .alu_zero(alu_zero), .alu_ovf(alu_ovf)
  );

  // 4-bit alu4 stand-in: [5:4] 0 B, 1 const 1, 2 const 0, 3 shift right with y entering the MSB
  always_comb begin
    logic [3:0] bb;
    logic [4:0] sum5;
    bb       = (alu_op[5:4] == 2'd0) ? alu_b : (alu_op[5:4] == 2'd1) ? 4'd1 : 4'd0;
    bb       = bb ^ {4{alu_binv}};
    sum5     = {1'b0, alu_a} + {1'b0, bb} + {4'd0, alu_y};
    alu_s    = 4'd0;
    alu_c    = 1'b0;
    alu_ovf  = 1'b0;
    if (alu_op[5:4] == 2'd3) begin
      alu_s = {alu_y, alu_a[3:1]};
      alu_c = alu_a[0];
    end else begin
      case (alu_op[1:0])
        2'd0: begin
          alu_s   = sum5[3:0];
          alu_c   = sum5[4];
          alu_ovf = (alu_a[3] == bb[3]) && (sum5[3] != alu_a[3]);
        end
        2'd1:    alu_s = alu_a | bb;
        2'd2:    alu_s = alu_a & bb;
        default: alu_s = alu_a ^ bb;
      endcase
    end
    alu_zero = (alu_s == 4'd0);
  end

  // Whole-operand result: {v, z, c, s}
  function automatic logic [W+2:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [5:0] op, input logic binv, input logic y);
    logic         yin, c, v;
    logic [W-1:0] bb, s;
    logic [W:0]   sum;
    case (op[3:2])
      2'd0:    yin = y;
      2'd1:    yin = 1'b1;
      2'd2:    yin = 1'b0;
      default: yin = binv ? a[0] : a[W-1];
    endcase
    c = 1'b0;
    v = 1'b0;
    if (op[5:4] == 2'd3) begin
      s = {yin, a[W-1:1]};
      c = a[0];
    end else begin
      bb = (op[5:4] == 2'd0) ? b : (op[5:4] == 2'd1) ? W'(1) : '0;
      if (binv) bb = ~bb;
      case (op[1:0])
        2'd0: begin
          sum = {1'b0, a} + {1'b0, bb} + (W+1)'(yin);
          s   = sum[W-1:0];
          c   = sum[W];
          v   = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
        end
        2'd1:    s = a | bb;
        2'd2:    s = a & bb;
        default: s = a ^ bb;
      endcase
    end
    return {v, (s == '0), c, s};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command, check latency and result; optionally complete the response handshake.
  task automatic run_cmd(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [5:0] op, input logic binv, input logic y,
                         input int hold, input bit finish_rsp);
    logic [W+2:0] exp;
    int k;
    exp = ref_model(a, b, op, binv, y);
    @(negedge clk);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_binv = binv; cmd_y = y; cmd_valid = 1'b1;
    check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_a = W'($urandom); cmd_b = W'($urandom); cmd_op = 6'($urandom);
    cmd_binv = 1'($urandom); cmd_y = 1'($urandom);
    k = 0;
    while (!rsp_valid && k < 40) begin
      if (k >= 1 && k <= N) begin
        slice_mode[k-1] = alu_op[5:4];
        if (alu_op[3:2] !== 2'b00 || alu_binv !== binv || alu_op[1:0] !== op[1:0]) alu_bad++;
      end
      @(negedge clk);
      k++;
    end
    check({tag, ".latency"}, 32'(k), 32'(N + 1));
    check({tag, ".s"}, 32'(rsp_s), 32'(exp[W-1:0]));
    check({tag, ".c"}, 32'(rsp_c), 32'(exp[W]));
    check({tag, ".z"}, 32'(rsp_z), 32'(exp[W+1]));
    check({tag, ".v"}, 32'(rsp_v), 32'(exp[W+2]));
    check({tag, ".first_mode"}, 32'(slice_mode[0]), 32'(op[5:4]));
    if (finish_rsp) begin
      repeat (hold) @(negedge clk);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, ".rsp_done"}, 32'(rsp_valid), 32'd0);
      check({tag, ".ready_back"}, 32'(cmd_ready), 32'd1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] s_hold;
    int rv_seen;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_binv = 1'b0; cmd_y = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset.rsp_s", 32'(rsp_s), 32'd0);
    check("reset.rsp_czv", 32'({rsp_c, rsp_z, rsp_v}), 32'd0);
    check("reset.alu", 32'({alu_a, alu_b, alu_binv, alu_y, alu_op}), 32'd0);
    rst_n = 1'b1;

    run_cmd("add", 16'h00FF, 16'h0001, 6'b000000, 1'b0, 1'b0, 0, 1'b1);
    run_cmd("sub", 16'h1234, 16'h1234, 6'b000100, 1'b1, 1'b0, 1, 1'b1);
    run_cmd("dec", 16'h1000, 16'h0000, 6'b010100, 1'b1, 1'b0, 0, 1'b1);
    check("dec.mode1", 32'(slice_mode[1]), 32'd2);
    check("dec.mode2", 32'(slice_mode[2]), 32'd2);
    check("dec.mode3", 32'(slice_mode[3]), 32'd2);
    run_cmd("asr", 16'h8002, 16'h0000, 6'b111101, 1'b0, 1'b0, 0, 1'b1);
    run_cmd("ror", 16'h0001, 16'h0000, 6'b111110, 1'b1, 1'b0, 2, 1'b1);
    run_cmd("ovf", 16'h7FFF, 16'h0001, 6'b000000, 1'b0, 1'b0, 0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      run_cmd("rand", W'($urandom), W'($urandom), 6'($urandom), 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)), 1'b1);
    end
    check("alu_fields", 32'(alu_bad), 32'd0);

    // Back-pressure: response must hold while a new command is offered
    run_cmd("stall", 16'hA5C3, 16'h0F0F, 6'b000011, 1'b0, 1'b0, 0, 1'b0);
    s_hold = rsp_s;
    cmd_a = 16'hFFFF; cmd_b = 16'h0001; cmd_op = 6'b000000; cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall.rsp_s", 32'(rsp_s), 32'(s_hold));
      check("stall.rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall.cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("stall.done_valid", 32'(rsp_valid), 32'd0);
    check("stall.done_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    check("stall.no_accept", 32'(cmd_ready), 32'd1);

    // Reset while slice 2 is on the alu bus
    @(negedge clk);
    cmd_a = 16'h1357; cmd_b = 16'h2468; cmd_op = 6'b000000; cmd_binv = 1'b0; cmd_y = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst.cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst.rsp_s", 32'(rsp_s), 32'd0);
    check("midrst.alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
    rv_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) rv_seen++;
    end
    check("midrst.no_rsp", 32'(rv_seen), 32'd0);
    run_cmd("after_rst", 16'h1357, 16'h2468, 6'b000000, 1'b0, 1'b1, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
